// File: rtl/jk_arb_pkg.sv
// jk_arb_pkg: op encodings and FSM states shared by jk_bank_arbiter and jk_cell.
package jk_arb_pkg;
    // An op's two bits are exactly the {j,k} pair applied to a selected cell.
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ACK  = 2'b10
    } state_t;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop with synchronous active-low clear.
module jk_cell
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);
    logic q_q, q_d;

    always_comb begin
        q_d = ({j, k} == OP_CLR) ? 1'b0 :
              ({j, k} == OP_SET) ? 1'b1 :
              ({j, k} == OP_TGL) ? ~q_q : q_q;
    end

    always_ff @(posedge clk) begin
        if (!clr) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q    = q_q;
    assign qbar = ~q_q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter driving a shared bank of W JK cells.
// Optional lock ownership (lock_a/lock_b ports) is built with JK_ARB_LOCK_EN.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req_a,
    input  logic [1:0]   op_a,
    input  logic [W-1:0] mask_a,
    input  logic         req_b,
    input  logic [1:0]   op_b,
    input  logic [W-1:0] mask_b,
`ifdef JK_ARB_LOCK_EN
    input  logic         lock_a,
    input  logic         lock_b,
`endif
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         busy,
    output logic [W-1:0] q,
    output logic [W-1:0] qbar
);
    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] mask_q, mask_d;
    logic         win_b_q, win_b_d;
    logic         last_b_q, last_b_d;
    logic         gnt_a_q, gnt_a_d;
    logic         gnt_b_q, gnt_b_d;
    logic         prio_b, pick_b;
    logic [W-1:0] j_bus, k_bus;

`ifdef JK_ARB_LOCK_EN
    logic own_v_q, own_v_d, own_b_q, own_b_d;
    assign prio_b = own_v_q ? own_b_q : !last_b_q;
`else
    assign prio_b = !last_b_q;
`endif
    assign pick_b = req_b && (!req_a || prio_b);

    // The grant cycle is skipped for arbitration: the served requester may still hold req.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mask_d   = mask_q;
        win_b_d  = win_b_q;
        last_b_d = last_b_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
`ifdef JK_ARB_LOCK_EN
        own_v_d  = own_v_q;
        own_b_d  = own_b_q;
`endif
        if (state_q == ST_IDLE) begin
            if ((req_a || req_b) && !gnt_a_q && !gnt_b_q) begin
                state_d = ST_EXEC;
                win_b_d = pick_b;
                op_d    = pick_b ? op_b : op_a;
                mask_d  = pick_b ? mask_b : mask_a;
            end
        end else if (state_q == ST_EXEC) begin
            state_d = ST_ACK;
        end else if (state_q == ST_ACK) begin
            state_d  = ST_IDLE;
            gnt_a_d  = !win_b_q;
            gnt_b_d  = win_b_q;
            last_b_d = win_b_q;
`ifdef JK_ARB_LOCK_EN
            if (win_b_q ? lock_b : lock_a) begin
                own_v_d = 1'b1;
                own_b_d = win_b_q;
            end else if (own_b_q == win_b_q) begin
                own_v_d = 1'b0;
            end
`endif
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_HOLD;
            mask_q   <= '0;
            win_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
`ifdef JK_ARB_LOCK_EN
            own_v_q  <= 1'b0;
            own_b_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mask_q   <= mask_d;
            win_b_q  <= win_b_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
`ifdef JK_ARB_LOCK_EN
            own_v_q  <= own_v_d;
            own_b_q  <= own_b_d;
`endif
        end
    end

    assign j_bus = (state_q == ST_EXEC) ? (mask_q & {W{op_q[1]}}) : '0;
    assign k_bus = (state_q == ST_EXEC) ? (mask_q & {W{op_q[0]}}) : '0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .clr  (clr),
            .j    (j_bus[i]),
            .k    (k_bus[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    assign busy  = (state_q != ST_IDLE);
    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, meaning the number of JK cells in the shared bank.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port req_a, input, 1 bit: requester A wants a bank operation.
REQ-005 SHALL have port op_a, input, 2 bits: A's operation; 00 hold, 01 clear, 10 set, 11 toggle.
REQ-006 SHALL have port mask_a, input, W bits: A's bit-select; 1 applies op_a to that cell.
REQ-007 SHALL have ports req_b, op_b and mask_b, identical to the A ports but for requester B.
REQ-008 SHALL have ports gnt_a and gnt_b, output, 1 bit each: one-cycle completion pulse to the served requester.
REQ-009 SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-010 SHALL have ports q and qbar, output, W bits each: bank state and its complement.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC and ACK.
REQ-012 SHALL, in IDLE with any req high at a rising edge, latch the winner's op and mask and go to EXEC.
REQ-013 SHALL, in IDLE with no req, stay in IDLE; bank j=k=0.
REQ-014 SHALL keep the bank j=k=0 in EXEC for cells whose latched mask bit is 0.
REQ-015 SHALL, in EXEC, drive each cell whose latched mask bit is 1 with j,k = latched op (clear j=0,k=1; set j=1,k=0; toggle j=1,k=1; hold j=0,k=0).
REQ-016 SHALL update the bank, and go to ACK, at the EXEC-exit edge.
REQ-017 SHALL, in ACK, assert the winner's gnt for exactly one cycle, then go to IDLE.
REQ-018 SHALL give a latency of q changing at edge N+1 and gnt high during cycle N+2 to N+3, where req is sampled at edge N.
REQ-019 SHALL arbitrate round-robin: a single request wins; on a simultaneous request the side not served last wins; after reset A has priority.
REQ-020 SHALL keep the loser's request pending, unlatched and unaffected.
REQ-021 SHALL make a requester hold req, op and mask stable until its gnt.
REQ-022 SHALL make a requester drop req in the cycle after its gnt, or it is re-arbitrated as a new request.
REQ-023 SHALL treat an operation with mask 0 or op 00 as a full transaction: gnt is issued and q is unchanged.
REQ-024 SHALL keep qbar equal to ~q at all times.
REQ-025 SHALL ignore req changes during EXEC and ACK (no abort).

Reset
REQ-026 SHALL, with clr low at a rising edge, set state IDLE, q=0, qbar all ones, gnt_a=gnt_b=0, busy=0, and round-robin priority to A.
REQ-027 SHALL let reset during EXEC or ACK abort the transaction: no gnt is issued and the bank is cleared regardless of the latched op.
REQ-028 SHALL give clr priority over every other input.

Configuration
REQ-029 SHALL, with JK_ARB_LOCK_EN defined, add inputs lock_a and lock_b (1 bit each).
REQ-030 SHALL, with JK_ARB_LOCK_EN defined, keep priority on a requester whose lock is high when its gnt issues, for the next arbitration, until that requester is granted with lock low.
REQ-031 SHALL, with JK_ARB_LOCK_EN undefined, have no lock ports and pure round-robin.
REQ-032 SHALL clear lock ownership on reset.

Structure
REQ-033 SHALL place op encoding constants (OP_HOLD, OP_CLR, OP_SET, OP_TGL) and FSM state encoding in shared package jk_arb_pkg.
REQ-034 SHALL instantiate sub-module jk_cell W times: one JK flip-flop (clk, clr synchronous active-low, j, k, q, qbar), 00 hold, 01 reset, 10 set, 11 toggle.

Verification
REQ-035 SHALL cover: clr low 2 cycles, then high -> q=8'h00, qbar=8'hFF, busy=0, no gnt.
REQ-036 SHALL cover: req_a=1, op_a=10, mask_a=8'h0F at edge N -> q=8'h0F at edge N+1, gnt_a pulse in cycle after N+2, gnt_b=0.
REQ-037 SHALL cover: from q=8'h0F, req_a and req_b both high (A op 11 mask 8'hFF, B op 01 mask 8'h03), A served last -> B first, q=8'h0C, then A, q=8'hF3; gnts in order b then a.
REQ-038 SHALL cover: req_b, op 11, mask 8'h00 -> gnt_b issued, q unchanged.
REQ-039 SHALL cover: clr low during EXEC of a set of 8'hFF -> q=8'h00 next edge, no gnt, IDLE.
REQ-040 SHALL cover, with JK_ARB_LOCK_EN defined: A locked, both requesting repeatedly -> A granted 3 times consecutively until lock_a low, then B granted.
